maze_collision_responder: RTL
=============================

Name: maze_collision_responder

Overview:
- Answers "can this sprite step one pixel in this direction?" for the Pac-Man and Ghost movers.
- Accepts a query (position plus direction) over a valid/ready handshake.
- Computes the two leading-edge corner pixels of the sprite after the step, reads the wall bitmap through a one-cycle-latency synchronous ROM port, and returns one bit: free or blocked.
- Keeps the last answer as a steady level so movers can poll it every cycle.

Parameters:
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.
- SPRITE, 16, sprite bounding-box edge in pixels (square box).
- TILE_SHIFT, 3, log2 of the tile edge (8-pixel tiles).
- MAP_W, 80, tiles per map row (SCREEN_W >> TILE_SHIFT).
- ADDR_W, 13, wall ROM address width (covers 80 x 60 = 4800 tiles).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  query present.
- req_ready  out  1  block can accept a query.
- req_x  in  10  sprite top-left X, pixels.
- req_y  in  9  sprite top-left Y, pixels.
- req_dir  in  2  direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- resp_valid  out  1  answer available.
- resp_ready  in  1  requester takes the answer.
- resp_free  out  1  answer: 1 = move allowed, 0 = blocked; valid while resp_valid is high.
- result  out  1  last answer, held until the next response completes.
- map_addr  out  ADDR_W  wall ROM address.
- map_data  in  1  wall bit for the address presented on the previous cycle (1 = wall).

Behaviour:
- Reset (rst low at a clk edge):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_free=0, result=0, map_addr=0.
  - Any query in flight is discarded. No response is issued for it.
- States: IDLE, CHECK, ADDR_A, ADDR_B, WAIT_B, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid and req_ready are both high in cycle N, capture x, y and dir, then go to CHECK.
  - req_ready is low in every other state. There is no queuing.
- CHECK (cycle N+1):
  - Compute the next position np from the captured x, y and dir.
  - Blocked-by-edge conditions: up with y==0; left with x==0; right with x+SPRITE >= SCREEN_W; down with y+SPRITE >= SCREEN_H.
  - If any condition holds: set resp_free=0 and go to RESP, so resp_valid is high at N+2.
  - Otherwise go to ADDR_A.
  - All sums use 11-bit intermediates so they cannot wrap.
- Leading-edge corners A and B, from np:
  - up: row np_y; columns np_x and np_x+SPRITE-1.
  - down: row np_y+SPRITE-1; columns np_x and np_x+SPRITE-1.
  - left: column np_x; rows np_y and np_y+SPRITE-1.
  - right: column np_x+SPRITE-1; rows np_y and np_y+SPRITE-1.
- Tile address: tile = pixel >> TILE_SHIFT; addr = tile_y*MAP_W + tile_x, truncated to ADDR_W bits.
- ROM read sequence:
  - ADDR_A (N+2): map_addr = address of corner A.
  - ADDR_B (N+3): map_addr = address of corner B; register map_data as wallA.
  - WAIT_B (N+4): register map_data as wallB.
  - Go to RESP. resp_valid is high at N+5.
- RESP:
  - resp_valid=1 and resp_free = ~(wallA | wallB).
  - resp_free stays stable while resp_ready is low.
  - On resp_ready: result <= resp_free, resp_valid drops, go to IDLE.
  - A new query is therefore accepted no earlier than the cycle after the response handshake.
- Outside ADDR_A and ADDR_B, map_addr holds its last value.
- req_x, req_y and req_dir may change after the accept cycle without affecting the answer.
- Reset asserted in any state overrides every transition in that same cycle.

Decomposition:
- Shared package maze_pkg holds:
  - direction constants DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11;
  - the FSM state encoding;
  - the SCREEN_W, SCREEN_H, SPRITE and TILE_SHIFT defaults.
- The Ghost and Pac-Man movers reuse the same direction constants.
- One combinational sub-module, edge_corner_gen, takes x, y and dir and produces the out-of-bounds flag plus the two corner tile addresses.
- The FSM and response registers stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=1, resp_valid=0, result=0, map_addr=0; no query is accepted while in reset.
- Open move: ROM all zeros, query x=200, y=146, dir=00 -> addresses (145>>3)*80+(200>>3)=1465 and 1466 appear at N+2 and N+3; resp_valid at N+5 with resp_free=1; after the handshake result=1.
- Wall hit: ROM bit 1466=1, same query -> resp_free=0 and result=0 after the handshake; also cover a wall on corner A only.
- Screen edge: x=0, dir=10 -> resp_valid at N+2, resp_free=0, map_addr unchanged; repeat with x=624, dir=11 (624+16=640).
- Backpressure and back-to-back: hold resp_ready=0 for 5 cycles -> resp_valid and resp_free stable, req_ready=0; release -> req_ready=1 the next cycle and a second query is accepted.
- Reset mid-operation: drive rst=0 during ADDR_B -> state returns to IDLE, resp_valid never asserts for that query, result=0.

Source files
------------

// File: rtl/maze_pkg.sv
// ============================================================================
// Module : maze_pkg
// Brief  : Shared maze constants: mover directions, playfield geometry
//          defaults and the collision-responder state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package maze_pkg;

    // Direction codes shared with the Pac-Man and Ghost movers
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_SPRITE     = 16;
    localparam int DEF_TILE_SHIFT = 3;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CHECK  = 3'd1;
    localparam state_t ST_ADDR_A = 3'd2;
    localparam state_t ST_ADDR_B = 3'd3;
    localparam state_t ST_WAIT_B = 3'd4;
    localparam state_t ST_RESP   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/edge_corner_gen.sv
// ============================================================================
// Module : edge_corner_gen
// Brief  : From a sprite position and step direction, flags a step off the
//          playfield and gives the wall-map tile addresses of the two
//          leading-edge corners after the step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_corner_gen
    import maze_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int SPRITE     = DEF_SPRITE,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_W      = SCREEN_W >> TILE_SHIFT,
    parameter int ADDR_W     = 13
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [1:0]        dir,
    output logic              oob,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b
);

    localparam logic [10:0] c_SPRITE   = 11'(SPRITE);
    localparam logic [10:0] c_SCREEN_W = 11'(SCREEN_W);
    localparam logic [10:0] c_SCREEN_H = 11'(SCREEN_H);

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [10:0] px,
                                                    input logic [10:0] py);
        logic [21:0] full;
        full = 22'(py >> TILE_SHIFT) * 22'(MAP_W) + 22'(px >> TILE_SHIFT);
        return full[ADDR_W-1:0];
    endfunction

    logic [10:0] w_x, w_y, w_np_x, w_np_y, w_hi_x, w_hi_y;
    logic [10:0] w_ax, w_ay, w_bx, w_by;

    always_comb begin
        w_x    = {1'b0, x};
        w_y    = {2'b00, y};
        w_np_x = w_x;
        w_np_y = w_y;
        oob    = 1'b0;
        case (dir)
            DIR_UP:    begin w_np_y = w_y - 11'd1; oob = (w_y == 11'd0); end
            DIR_DOWN:  begin w_np_y = w_y + 11'd1; oob = (w_y + c_SPRITE >= c_SCREEN_H); end
            DIR_LEFT:  begin w_np_x = w_x - 11'd1; oob = (w_x == 11'd0); end
            DIR_RIGHT: begin w_np_x = w_x + 11'd1; oob = (w_x + c_SPRITE >= c_SCREEN_W); end
        endcase
        w_hi_x = w_np_x + c_SPRITE - 11'd1;
        w_hi_y = w_np_y + c_SPRITE - 11'd1;

        // Corner A is always the lower coordinate along the leading edge
        w_ax = w_np_x;
        w_ay = w_np_y;
        w_bx = w_hi_x;
        w_by = w_np_y;
        case (dir)
            DIR_UP:    begin w_ax = w_np_x; w_ay = w_np_y; w_bx = w_hi_x; w_by = w_np_y; end
            DIR_DOWN:  begin w_ax = w_np_x; w_ay = w_hi_y; w_bx = w_hi_x; w_by = w_hi_y; end
            DIR_LEFT:  begin w_ax = w_np_x; w_ay = w_np_y; w_bx = w_np_x; w_by = w_hi_y; end
            DIR_RIGHT: begin w_ax = w_hi_x; w_ay = w_np_y; w_bx = w_hi_x; w_by = w_hi_y; end
        endcase
        addr_a = tile_addr(w_ax, w_ay);
        addr_b = tile_addr(w_bx, w_by);
    end

endmodule

`default_nettype wire

// File: rtl/maze_collision_responder.sv
// ============================================================================
// Module : maze_collision_responder
// Brief  : Answers "may this sprite step one pixel?" by probing the two
//          leading-edge corner tiles in a one-cycle-latency wall ROM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_collision_responder
    import maze_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int SPRITE     = DEF_SPRITE,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_W      = SCREEN_W >> TILE_SHIFT,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [8:0]        req_y,
    input  logic [1:0]        req_dir,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_free,
    output logic              result,
    output logic [ADDR_W-1:0] map_addr,
    input  logic              map_data
);

    state_t            r_state, w_next;
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [1:0]        r_dir;
    logic              r_wall_a, r_wall_b;
    logic              w_oob;
    logic [ADDR_W-1:0] w_addr_a, w_addr_b;

    edge_corner_gen #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .SPRITE     (SPRITE),
        .TILE_SHIFT (TILE_SHIFT),
        .MAP_W      (MAP_W),
        .ADDR_W     (ADDR_W)
    ) u_corner (
        .x      (r_x),
        .y      (r_y),
        .dir    (r_dir),
        .oob    (w_oob),
        .addr_a (w_addr_a),
        .addr_b (w_addr_b)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = ST_CHECK;
            ST_CHECK:  w_next = w_oob ? ST_RESP : ST_ADDR_A;
            ST_ADDR_A: w_next = ST_ADDR_B;
            ST_ADDR_B: w_next = ST_WAIT_B;
            ST_WAIT_B: w_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_free  = resp_valid & ~(r_wall_a | r_wall_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= DIR_UP;
            r_wall_a <= 1'b0;
            r_wall_b <= 1'b0;
            map_addr <= '0;
            result   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_x   <= req_x;
                        r_y   <= req_y;
                        r_dir <= req_dir;
                    end
                end
                ST_CHECK: begin
                    // An off-screen step is reported as a wall on corner A
                    r_wall_a <= w_oob;
                    r_wall_b <= 1'b0;
                    if (!w_oob) map_addr <= w_addr_a;
                end
                ST_ADDR_A: map_addr <= w_addr_b;
                ST_ADDR_B: r_wall_a <= map_data;
                ST_WAIT_B: r_wall_b <= map_data;
                ST_RESP:   if (resp_ready) result <= resp_free;
                default:   ;
            endcase
        end
    end

endmodule

`default_nettype wire
